ahb2apb_bridge: RTL and testbench
=================================

AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

Interface
REQ-001 SHALL have parameter AWIDTH, default 10, address width in bits for both haddr and paddr.
REQ-002 SHALL have parameter DSIZE, 3 bits, default 2, data size; DBYTES=1<<DSIZE and DWIDTH=DBYTES*8 are derived.
REQ-003 SHALL have one clock and a synchronous, active-high reset: hclk is the only clock, and hreset is sampled only on rising hclk.
REQ-004 SHALL have these ports, clock and reset first (name, direction, width, meaning):
- hclk  in  1  clock
- hreset  in  1  synchronous active-high reset
- hsel  in  1  slave select
- hready  in  1  bus ready
- htrans  in  2  transfer type
- hwrite  in  1  write
- hsize  in  3  transfer size
- hprot  in  4  protection
- haddr  in  AWIDTH  address
- hwdata  in  DWIDTH  write data
- hrdata  out  DWIDTH  read data
- hreadyout  out  1  transfer done
- hresp  out  1  error response
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB write
- pprot  out  3  APB protection
- paddr  out  AWIDTH  APB address
- pstrb  out  DBYTES  write strobes
- pwdata  out  DWIDTH  APB write data
- prdata  in  DWIDTH  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error

Function
REQ-005 SHALL accept a transfer when hsel & hready & htrans[1] is sampled high in state IDLE, DONE or ERR2; the bridge ignores the IDLE and BUSY transfer types.
REQ-006 On acceptance, SHALL register haddr, hwrite, hsize and hprot, then enter LATCH.
REQ-007 SHALL run the FSM states IDLE, LATCH, SETUP, ACCESS, DONE, ERR1 and ERR2.
REQ-008 LATCH SHALL last 1 cycle: it registers hwdata into pwdata when the transfer is a write, then moves to SETUP.
REQ-009 SETUP SHALL drive psel=1 and penable=0, then move to ACCESS.
REQ-010 ACCESS SHALL drive psel=1 and penable=1, holding every APB output stable until pready=1.
REQ-011 In ACCESS with pready=1, SHALL register prdata into hrdata on reads, then go to DONE, or to ERR1 per REQ-020.
REQ-012 psel and penable SHALL both be 0 in IDLE, LATCH, DONE, ERR1 and ERR2.
REQ-013 SHALL drive hreadyout=1 only in IDLE, DONE and ERR2, and 0 in every other state.
REQ-014 DONE and ERR2 SHALL last 1 cycle; each goes to LATCH if a transfer is accepted that cycle, otherwise to IDLE.
REQ-015 Zero-wait-state latency SHALL be: address phase in cycle N, SETUP in N+2, ACCESS in N+3, and hreadyout=1 with valid hrdata in N+4.
REQ-016 pstrb SHALL follow these rules:
- Reads: all zeros.
- Writes: (1<<(1<<hsize))-1 shifted left by haddr[DSIZE-1:0], truncated to DBYTES bits.
REQ-017 paddr SHALL equal the registered haddr unmodified, with no alignment applied.
REQ-018 pprot SHALL be mapped from hprot as follows: pprot[0]=hprot[1], pprot[1]=1, pprot[2]=~hprot[0].
REQ-019 hresp SHALL be 1 exactly in ERR1 and ERR2.

Configuration
REQ-020 When macro AHB2APB_ERR_EN is defined, SHALL apply these error rules:
- ACCESS with pready=1 and pslverr=1 goes to ERR1 then ERR2, giving the two-cycle AHB error response.
- An accepted transfer with hsize>DSIZE goes LATCH->ERR1 with no APB access (psel stays 0).
REQ-021 When AHB2APB_ERR_EN is undefined, SHALL apply these rules instead:
- pslverr is ignored.
- The ERR states are unreachable and hresp is tied 0.
- hsize>DSIZE is treated as hsize=DSIZE, so pstrb is all ones on writes.

Reset
REQ-022 While hreset=1 at a rising hclk, SHALL load these values:
- state IDLE
- psel=0, penable=0, pwrite=0
- paddr=0, pwdata=0, pstrb=0, pprot=0
- hrdata=0
- hreadyout=1, hresp=0
REQ-023 Reset in any state, including mid-ACCESS, SHALL abort the transfer: the APB signals drop at that edge and no AHB response is produced for it.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Write word: haddr=0x010, hsize=2, hwdata=0xDEADBEEF, pready=1 -> SETUP paddr=0x010, pwdata=0xDEADBEEF, pstrb=4'hF; hreadyout=1 at N+4.
- Read word with 2 wait states: haddr=0x020, prdata=0x12345678, pready low for 2 ACCESS cycles -> penable high 3 cycles, hrdata=0x12345678 at N+6, pstrb=0.
- Byte write: haddr=0x013, hsize=0 -> pstrb=4'b1000. Halfword write: haddr=0x012, hsize=1 -> pstrb=4'b1100.
- With AHB2APB_ERR_EN, pslverr=1 at pready -> hresp=1 for 2 cycles, hreadyout 0 then 1. With AHB2APB_ERR_EN, hsize=3 -> error and psel never asserted. Without the macro, hresp stays 0 in both cases.
- Back-to-back: second transfer presented in DONE -> LATCH next cycle, with no IDLE cycle between the two APB accesses.
- Reset: hreset=1 during ACCESS -> next cycle psel=0, penable=0, hreadyout=1, hresp=0, state IDLE.

Source files
------------

// File: rtl/ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ahb2apb_bridge
// Description : AHB-Lite slave to APB master bridge. Each accepted AHB
//               transfer is registered (LATCH), then presented to APB as a
//               SETUP/ACCESS pair. The AHB response is returned one cycle
//               after the APB access completes.
//
// Parameters  : AWIDTH - address width of haddr and paddr
//               DSIZE  - log2 of data bytes (DBYTES = 1<<DSIZE, DWIDTH = 8*DBYTES)
//
// Ports       : hclk, hreset        - clock, synchronous active-high reset
//               hsel, hready, htrans, hwrite, hsize, hprot, haddr, hwdata
//                                   - AHB address/data phase inputs
//               hrdata, hreadyout, hresp
//                                   - AHB response outputs
//               psel, penable, pwrite, pprot, paddr, pstrb, pwdata
//                                   - APB request outputs (all registered)
//               prdata, pready, pslverr
//                                   - APB completion inputs
//
// Build option: define AHB2APB_ERR_EN to return AHB ERROR responses for
//               pslverr and for transfers wider than the data bus. Without it
//               pslverr is ignored, hresp is always 0 and oversized transfers
//               are handled as full-width ones.
//
// Revision    : 1.0 - initial release
// ============================================================================
module ahb2apb_bridge #(
    parameter int          AWIDTH = 10,
    parameter logic [2:0]  DSIZE  = 3'd2,
    localparam int         DBYTES = 1 << DSIZE,
    localparam int         DWIDTH = DBYTES * 8
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic              hready,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [3:0]        hprot,
    input  logic [AWIDTH-1:0] haddr,
    input  logic [DWIDTH-1:0] hwdata,
    output logic [DWIDTH-1:0] hrdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [2:0]        pprot,
    output logic [AWIDTH-1:0] paddr,
    output logic [DBYTES-1:0] pstrb,
    output logic [DWIDTH-1:0] pwdata,
    input  logic [DWIDTH-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_DONE   = 3'd4,
        S_ERR1   = 3'd5,
        S_ERR2   = 3'd6
    } state_t;

    state_t r_state;

    // ------------------------------------------------------------------------
    // Acceptance: only NONSEQ/SEQ (htrans[1]=1) while the bridge is ready.
    // ------------------------------------------------------------------------
    logic w_ready_state;
    logic w_accept;

    assign w_ready_state = (r_state == S_IDLE) || (r_state == S_DONE) ||
                           (r_state == S_ERR2);
    assign w_accept      = w_ready_state & hsel & hready & htrans[1];

    // ------------------------------------------------------------------------
    // Write strobes. The transfer size is clamped to the bus width so the
    // mask never exceeds DBYTES lanes; the lane offset comes from the low
    // address bits and anything shifted past the top lane is dropped.
    // ------------------------------------------------------------------------
    logic [2:0]        w_size_eff;
    logic [DBYTES-1:0] w_mask;
    logic [DBYTES-1:0] w_strb;

    assign w_size_eff = (hsize > DSIZE) ? DSIZE : hsize;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DBYTES; i++) begin
            w_mask[i] = (32'(i) < (32'd1 << w_size_eff));
        end
    end

    generate
        if (DSIZE == 3'd0) begin : g_no_offset
            assign w_strb = w_mask;
        end else begin : g_offset
            assign w_strb = w_mask << haddr[int'(DSIZE)-1:0];
        end
    endgenerate

    logic [2:0] w_pprot;
    assign w_pprot = {~hprot[0], 1'b1, hprot[1]};

`ifdef AHB2APB_ERR_EN
    // Oversized transfer flag, captured with the address phase.
    logic r_size_err;
    logic w_unused;
    assign w_unused = ^{hprot[3:2], htrans[0]};
`else
    logic w_unused;
    assign w_unused = ^{hprot[3:2], htrans[0], pslverr};
`endif

    // ------------------------------------------------------------------------
    // Control FSM. Every bus output is registered here and updated together
    // with the state it belongs to.
    // ------------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state   <= S_IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            pprot     <= '0;
            hrdata    <= '0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
`ifdef AHB2APB_ERR_EN
            r_size_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR2: begin
                    hresp <= 1'b0;
                    if (w_accept) begin
                        r_state   <= S_LATCH;
                        hreadyout <= 1'b0;
                        paddr     <= haddr;
                        pwrite    <= hwrite;
                        pprot     <= w_pprot;
                        pstrb     <= hwrite ? w_strb : '0;
`ifdef AHB2APB_ERR_EN
                        r_size_err <= (hsize > DSIZE);
`endif
                    end else begin
                        r_state   <= S_IDLE;
                        hreadyout <= 1'b1;
                    end
                end

                S_LATCH: begin
                    // AHB write data is valid in the data phase, i.e. now.
                    if (pwrite) begin
                        pwdata <= hwdata;
                    end
`ifdef AHB2APB_ERR_EN
                    if (r_size_err) begin
                        r_state <= S_ERR1;
                        hresp   <= 1'b1;
                    end else
`endif
                    begin
                        r_state <= S_SETUP;
                        psel    <= 1'b1;
                    end
                end

                S_SETUP: begin
                    r_state <= S_ACCESS;
                    penable <= 1'b1;
                end

                S_ACCESS: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (!pwrite) begin
                            hrdata <= prdata;
                        end
`ifdef AHB2APB_ERR_EN
                        if (pslverr) begin
                            r_state <= S_ERR1;
                            hresp   <= 1'b1;
                        end else
`endif
                        begin
                            r_state   <= S_DONE;
                            hreadyout <= 1'b1;
                        end
                    end
                end

                // First cycle of the two-cycle ERROR response: hready low.
                S_ERR1: begin
                    r_state   <= S_ERR2;
                    hreadyout <= 1'b1;
                end

                default: begin
                    r_state   <= S_IDLE;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb2apb_bridge
// Description : Self-checking bench for ahb2apb_bridge. Directed transfers
//               followed by randomized ones; every transfer is predicted by a
//               transaction-level model of the bridge timing, strobes,
//               protection mapping and error handling.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb2apb_bridge;

    localparam int         AWIDTH = 10;
    localparam logic [2:0] DSIZE  = 3'd2;
    localparam int         DBYTES = 4;
    localparam int         DWIDTH = 32;

`ifdef AHB2APB_ERR_EN
    localparam bit c_ERR_EN = 1'b1;
`else
    localparam bit c_ERR_EN = 1'b0;
`endif

    logic              hclk = 1'b0;
    logic              hreset;
    logic              hsel;
    logic              hready;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [3:0]        hprot;
    logic [AWIDTH-1:0] haddr;
    logic [DWIDTH-1:0] hwdata;
    logic [DWIDTH-1:0] hrdata;
    logic              hreadyout;
    logic              hresp;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [2:0]        pprot;
    logic [AWIDTH-1:0] paddr;
    logic [DBYTES-1:0] pstrb;
    logic [DWIDTH-1:0] pwdata;
    logic [DWIDTH-1:0] prdata;
    logic              pready;
    logic              pslverr;

    int n_checks = 0;
    int n_errors = 0;

    ahb2apb_bridge #(
        .AWIDTH (AWIDTH),
        .DSIZE  (DSIZE)
    ) u_dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hsel),
        .hready    (hready),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hprot     (hprot),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pprot     (pprot),
        .paddr     (paddr),
        .pstrb     (pstrb),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: lanes touched by a write, from size and address offset.
    function automatic logic [3:0] model_strb(input logic [9:0] a, input int sz, input bit wr);
        int nbytes;
        int ofs;
        int szc;
        if (!wr) return 4'h0;
        szc    = (sz > 2) ? 2 : sz;
        nbytes = 1 << szc;
        ofs    = int'(a) % 4;
        return 4'(((1 << nbytes) - 1) << ofs);
    endfunction

    function automatic logic [2:0] model_prot(input logic [3:0] p);
        return {~p[0], 1'b1, p[1]};
    endfunction

    task automatic drive_idle();
        hsel   = 1'b0;
        hready = 1'b1;
        htrans = 2'b00;
    endtask

    // One complete transfer. Entered at a falling edge where the bridge is
    // ready; returns at the falling edge of the last response cycle so the
    // caller may present the next transfer there (back-to-back).
    task automatic run_xfer(input logic [9:0] a, input bit wr, input int sz,
                            input logic [3:0] prot, input logic [31:0] wd,
                            input logic [31:0] rd, input int waits, input bit serr);
        bit size_err;
        bit resp_err;
        size_err = c_ERR_EN && (sz > 2);
        resp_err = c_ERR_EN && serr;

        // Address phase (cycle N)
        hsel   = 1'b1;
        hready = 1'b1;
        htrans = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
        hwrite = wr;
        hsize  = 3'(sz);
        hprot  = prot;
        haddr  = a;
        @(negedge hclk);

        // N+1: data phase; scramble address-phase inputs to prove they were captured
        drive_idle();
        haddr  = 10'($urandom);
        hwrite = 1'($urandom);
        hsize  = 3'($urandom);
        hprot  = 4'($urandom);
        hwdata = wd;
        chk("latch_hreadyout", hreadyout, 1'b0);
        chk("latch_psel", psel, 1'b0);
        chk("latch_hresp", hresp, 1'b0);
        @(negedge hclk);
        hwdata = $urandom;

        if (size_err) begin
            chk("szerr1_hresp", hresp, 1'b1);
            chk("szerr1_hreadyout", hreadyout, 1'b0);
            chk("szerr1_psel", psel, 1'b0);
            @(negedge hclk);
            chk("szerr2_hresp", hresp, 1'b1);
            chk("szerr2_hreadyout", hreadyout, 1'b1);
            chk("szerr2_psel", psel, 1'b0);
            return;
        end

        // N+2: SETUP
        chk("setup_psel", psel, 1'b1);
        chk("setup_penable", penable, 1'b0);
        chk("setup_paddr", paddr, a);
        chk("setup_pwrite", pwrite, wr);
        chk("setup_pstrb", pstrb, model_strb(a, sz, wr));
        chk("setup_pprot", pprot, model_prot(prot));
        if (wr) chk("setup_pwdata", pwdata, wd);

        // N+3 .. N+3+waits: ACCESS
        for (int k = 0; k <= waits; k++) begin
            @(negedge hclk);
            chk("access_psel", psel, 1'b1);
            chk("access_penable", penable, 1'b1);
            chk("access_paddr", paddr, a);
            chk("access_pstrb", pstrb, model_strb(a, sz, wr));
            chk("access_hreadyout", hreadyout, 1'b0);
            if (wr) chk("access_pwdata", pwdata, wd);
            pready  = (k == waits);
            prdata  = (k == waits) ? rd : $urandom;
            pslverr = (k == waits) ? serr : 1'($urandom);
        end

        // Response
        @(negedge hclk);
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = $urandom;
        chk("resp_psel", psel, 1'b0);
        chk("resp_penable", penable, 1'b0);
        if (!wr) chk("resp_hrdata", hrdata, rd);
        if (resp_err) begin
            chk("slverr1_hresp", hresp, 1'b1);
            chk("slverr1_hreadyout", hreadyout, 1'b0);
            @(negedge hclk);
            chk("slverr2_hresp", hresp, 1'b1);
            chk("slverr2_hreadyout", hreadyout, 1'b1);
        end else begin
            chk("done_hreadyout", hreadyout, 1'b1);
            chk("done_hresp", hresp, 1'b0);
        end
    endtask

    initial begin
        hreset  = 1'b1;
        drive_idle();
        hwrite  = 1'b0;
        hsize   = 3'd0;
        hprot   = 4'h0;
        haddr   = '0;
        hwdata  = '0;
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        repeat (3) @(negedge hclk);

        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_pwrite", pwrite, 1'b0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_pprot", pprot, 0);
        chk("rst_hrdata", hrdata, 0);
        chk("rst_hreadyout", hreadyout, 1'b1);
        chk("rst_hresp", hresp, 1'b0);
        hreset = 1'b0;
        @(negedge hclk);

        // Directed transfers
        run_xfer(10'h010, 1'b1, 2, 4'h3, 32'hDEADBEEF, 32'h0, 0, 1'b0);
        @(negedge hclk);
        run_xfer(10'h020, 1'b0, 2, 4'h0, 32'h0, 32'h12345678, 2, 1'b0);
        @(negedge hclk);
        run_xfer(10'h013, 1'b1, 0, 4'h1, 32'hAA000000, 32'h0, 0, 1'b0);
        chk("byte_strb_rule", 64'(model_strb(10'h013, 0, 1'b1)), 64'h8);
        run_xfer(10'h012, 1'b1, 1, 4'h2, 32'hBBBB0000, 32'h0, 1, 1'b0);
        @(negedge hclk);
        run_xfer(10'h034, 1'b0, 2, 4'h1, 32'h0, 32'hCAFEF00D, 0, 1'b1);
        @(negedge hclk);
        run_xfer(10'h040, 1'b1, 3, 4'h0, 32'h01020304, 32'h0, 0, 1'b0);
        // Back-to-back: next transfer presented in the response cycle
        run_xfer(10'h044, 1'b0, 2, 4'h2, 32'h0, 32'h0BADC0DE, 1, 1'b0);
        run_xfer(10'h048, 1'b1, 2, 4'h3, 32'h55AA55AA, 32'h0, 0, 1'b0);
        @(negedge hclk);

        // Reset during ACCESS aborts the transfer
        hsel = 1'b1; hready = 1'b1; htrans = 2'b10; hwrite = 1'b1;
        hsize = 3'd2; hprot = 4'h2; haddr = 10'h0F4;
        @(negedge hclk);
        drive_idle();
        hwdata = 32'h11223344;
        @(negedge hclk);                    // SETUP
        @(negedge hclk);                    // ACCESS
        chk("pre_rst_penable", penable, 1'b1);
        hreset = 1'b1;
        @(negedge hclk);
        chk("midrst_psel", psel, 1'b0);
        chk("midrst_penable", penable, 1'b0);
        chk("midrst_hreadyout", hreadyout, 1'b1);
        chk("midrst_hresp", hresp, 1'b0);
        chk("midrst_paddr", paddr, 0);
        chk("midrst_pstrb", pstrb, 0);
        hreset = 1'b0;
        pready = 1'b1;
        @(negedge hclk);
        pready = 1'b0;
        chk("postrst_psel", psel, 1'b0);
        chk("postrst_hreadyout", hreadyout, 1'b1);
        chk("postrst_hresp", hresp, 1'b0);

        // Ignored transfer types: IDLE and BUSY with hsel asserted
        hsel = 1'b1; hready = 1'b1; htrans = 2'b01; haddr = 10'h3FF; hwrite = 1'b1;
        @(negedge hclk);
        chk("busy_ignored_hreadyout", hreadyout, 1'b1);
        htrans = 2'b00;
        @(negedge hclk);
        chk("idle_ignored_hreadyout", hreadyout, 1'b1);
        // hready low from another slave: no acceptance
        htrans = 2'b10; hready = 1'b0;
        @(negedge hclk);
        chk("hready_low_ignored", hreadyout, 1'b1);
        drive_idle();

        // Randomized transfers
        for (int t = 0; t < 60; t++) begin
            logic [9:0] ra;
            bit         rw;
            int         rsz;
            ra  = 10'($urandom);
            rw  = 1'($urandom);
            rsz = $urandom_range(0, 3);
            run_xfer(ra, rw, rsz, 4'($urandom), $urandom, $urandom,
                     $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
            repeat ($urandom_range(0, 2)) begin
                @(negedge hclk);
                chk("gap_hreadyout", hreadyout, 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
